// File: rtl/cdc_pkg.sv
// Shared clock-domain-crossing constants for synchronizer, pulse-sync and handshake blocks.
package cdc_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    function automatic logic sync_stages_legal(input int unsigned stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/sync_cell.sv
// Per-bit multi-flop level synchronizer into the clk domain, with rise/fall/edge pulses
// derived from the synchronized value and a one-cycle history register.
module sync_cell
    import cdc_pkg::*;
#(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      STAGES  = SYNC_STAGES_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall,
    output logic [WIDTH-1:0] out_edge
);

    if (!sync_stages_legal(STAGES)) begin : g_bad_stages
        $error("sync_cell: STAGES=%0d outside %0d..%0d", STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    logic [WIDTH-1:0] out_dly;

    // Independent chain per bit; only chain[0] samples the asynchronous input.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] chain;

        always_ff @(posedge clk) begin
            if (rst) begin
                chain <= {STAGES{RST_VAL[i]}};
            end else begin
                chain <= {chain[STAGES-2:0], in[i]};
            end
        end

        assign out[i] = chain[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_dly <= RST_VAL;
        end else begin
            out_dly <= out;
        end
    end

    // Reset loads chain and history alike, so no pulse comes out of reset itself.
    assign out_rise = out & ~out_dly;
    assign out_fall = ~out & out_dly;
    assign out_edge = out ^ out_dly;

endmodule

// File: tb/tb_sync_cell.sv
// Self-checking bench for sync_cell: event-queue scoreboard for a 4-bit/2-stage instance,
// explicit expectation queue for a 1-bit/3-stage instance, and async-source sequence checks.
module tb_sync_cell;

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] e;
    } obs_t;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    typedef struct {
        int   cyc;
        logic o;
        logic r;
    } ev3_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'b0000;
    logic [3:0] dout, drise, dfall, dedge;
    logic       in3 = 1'b0;
    logic       out3, rise3, fall3, edge3;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    ev_t        q[$];
    ev3_t       q3[$];
    logic [3:0] m_out, m_prev;

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sync_cell #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (din),
        .out      (dout),
        .out_rise (drise),
        .out_fall (dfall),
        .out_edge (dedge)
    );

    sync_cell #(.WIDTH(1), .STAGES(3), .RST_VAL(1'b0)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .in       (in3),
        .out      (out3),
        .out_rise (rise3),
        .out_fall (fall3),
        .out_edge (edge3)
    );

    // Expected outputs for the current cycle: a value pushed at cycle c is due on out at c+2.
    function automatic obs_t model_tick();
        obs_t e;
        ev_t  t;
        if (rst) begin
            q.delete();
            m_out  = 4'b0000;
            m_prev = 4'b0000;
        end else begin
            m_prev = m_out;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                t     = q.pop_front();
                m_out = t.val;
            end
        end
        e.o = m_out;
        e.r = m_out & ~m_prev;
        e.f = ~m_out & m_prev;
        e.e = m_out ^ m_prev;
        return e;
    endfunction

    function automatic void push_in();
        ev_t t;
        t.cyc = cyc + 2;
        t.val = din;
        q.push_back(t);
    endfunction

    task automatic test_reset();
        obs_t e, g;
        int rises = 0;
        int falls = 0;
        rst = 1'b1;
        din = 4'b0001;
        in3 = 1'b0;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            e = model_tick();
            g = {dout, drise, dfall, dedge};
            checks++;
            if (g !== e) $display("FAIL reset_hold cyc=%0d got %h want %h", cyc, g, e);
            else passes++;
        end
        checks++;
        if ({out3, rise3, fall3, edge3} !== 4'b0000)
            $display("FAIL reset_s3 got %b want 0000", {out3, rise3, fall3, edge3});
        else passes++;
        rst = 1'b0;
        push_in();
        repeat (4) begin
            @(negedge clk);
            e = model_tick();
            g = {dout, drise, dfall, dedge};
            checks++;
            if (g !== e) $display("FAIL reset_release cyc=%0d got %h want %h", cyc, g, e);
            else passes++;
            if (drise[0]) rises++;
            if (dfall[0]) falls++;
        end
        checks++;
        if (rises !== 1 || falls !== 0)
            $display("FAIL reset_release_pulses got rise=%0d fall=%0d want rise=1 fall=0", rises, falls);
        else passes++;
    endtask

    task automatic test_latency();
        obs_t e, g;
        ev3_t t3;
        din = 4'b0000;
        push_in();
        repeat (4) begin
            @(negedge clk);
            e = model_tick();
            g = {dout, drise, dfall, dedge};
            checks++;
            if (g !== e) $display("FAIL latency_s2_low cyc=%0d got %h want %h", cyc, g, e);
            else passes++;
        end
        din = 4'b0001;
        in3 = 1'b1;
        push_in();
        q3.push_back('{cyc + 1, 1'b0, 1'b0});
        q3.push_back('{cyc + 2, 1'b0, 1'b0});
        q3.push_back('{cyc + 3, 1'b1, 1'b1});
        q3.push_back('{cyc + 4, 1'b1, 1'b0});
        repeat (4) begin
            @(negedge clk);
            e = model_tick();
            g = {dout, drise, dfall, dedge};
            checks++;
            if (g !== e) $display("FAIL latency_s2_high cyc=%0d got %h want %h", cyc, g, e);
            else passes++;
            if (q3.size() > 0 && q3[0].cyc == cyc) begin
                t3 = q3.pop_front();
                checks++;
                if ({out3, rise3} !== {t3.o, t3.r})
                    $display("FAIL latency_s3 cyc=%0d got out=%b rise=%b want out=%b rise=%b",
                             cyc, out3, rise3, t3.o, t3.r);
                else passes++;
            end
        end
        checks++;
        if (q3.size() != 0) $display("FAIL latency_s3_drain got %0d left want 0", q3.size());
        else passes++;
    endtask

    task automatic test_toggle();
        obs_t e, g;
        int edges = 0;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            e = model_tick();
            g = {dout, drise, dfall, dedge};
            checks++;
            if (g !== e) $display("FAIL toggle cyc=%0d got %h want %h", cyc, g, e);
            else passes++;
            if (dedge[0]) edges++;
            if (i < 40 && (i % 4) == 0) begin
                din[0] = ~din[0];
                push_in();
            end
        end
        checks++;
        if (edges !== 10) $display("FAIL toggle_count got %0d want 10", edges);
        else passes++;
    endtask

    task automatic test_reset_midflight();
        obs_t e, g;
        int rises = 0;
        din = 4'b0000;
        push_in();
        repeat (4) begin
            @(negedge clk);
            e = model_tick();
            g = {dout, drise, dfall, dedge};
            checks++;
            if (g !== e) $display("FAIL midflight_settle cyc=%0d got %h want %h", cyc, g, e);
            else passes++;
        end
        din = 4'b0001;
        push_in();
        @(negedge clk);
        e = model_tick();
        g = {dout, drise, dfall, dedge};
        checks++;
        if (g !== e) $display("FAIL midflight_captured cyc=%0d got %h want %h", cyc, g, e);
        else passes++;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            e = model_tick();
            g = {dout, drise, dfall, dedge};
            checks++;
            if (g !== 16'h0000) $display("FAIL midflight_discard cyc=%0d got %h want 0000", cyc, g);
            else passes++;
        end
        rst = 1'b0;
        push_in();
        repeat (4) begin
            @(negedge clk);
            e = model_tick();
            g = {dout, drise, dfall, dedge};
            checks++;
            if (g !== e) $display("FAIL midflight_release cyc=%0d got %h want %h", cyc, g, e);
            else passes++;
            if (drise[0]) rises++;
        end
        checks++;
        if (rises !== 1) $display("FAIL midflight_rise_count got %0d want 1", rises);
        else passes++;
    endtask

    task automatic test_multibit();
        obs_t e, g;
        logic [3:0] seq [3];
        seq[0] = 4'b0000;
        seq[1] = 4'b0101;
        seq[2] = 4'b0100;
        for (int s = 0; s < 3; s++) begin
            din = seq[s];
            push_in();
            repeat (4) begin
                @(negedge clk);
                e = model_tick();
                g = {dout, drise, dfall, dedge};
                checks++;
                if (g !== e) $display("FAIL multibit step%0d cyc=%0d got %h want %h", s, cyc, g, e);
                else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        logic [3:0] seq [4];
        seq[0] = 4'b1010;
        seq[1] = 4'b0101;
        seq[2] = 4'b1111;
        seq[3] = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            din = seq[s];
            push_in();
            repeat ((s == 3) ? 5 : 2) begin
                @(negedge clk);
                e = model_tick();
                g = {dout, drise, dfall, dedge};
                checks++;
                if (g !== e) $display("FAIL back_to_back step%0d cyc=%0d got %h want %h", s, cyc, g, e);
                else passes++;
            end
        end
    endtask

    // Source toggles bit 0 on its own timebase; levels always held at least two clk periods.
    task automatic test_async(input int per, input int lo, input int hi);
        logic aq[$];
        logic done = 1'b0;
        logic v;
        fork
            begin
                #1;
                for (int k = 0; k < 12; k++) begin
                    din[0] = ~din[0];
                    aq.push_back(din[0]);
                    #(per * int'($urandom_range(hi, lo)));
                end
                done = 1'b1;
            end
            begin
                int budget = 0;
                int settle = 0;
                while (settle < 6 && budget < 2000) begin
                    @(negedge clk);
                    budget++;
                    if (done) settle++;
                    if (dedge[0]) begin
                        checks++;
                        if (aq.size() == 0) begin
                            $display("FAIL async_p%0d extra edge cyc=%0d got out=%b want none", per, cyc, dout[0]);
                        end else begin
                            v = aq.pop_front();
                            if (dout[0] !== v)
                                $display("FAIL async_p%0d cyc=%0d got out=%b want %b", per, cyc, dout[0], v);
                            else passes++;
                        end
                    end
                end
                if (budget >= 2000) begin
                    checks++;
                    $display("FAIL async_p%0d timeout got %0d cycles want <2000", per, budget);
                end
            end
        join
        checks++;
        if (aq.size() != 0 || dout !== din)
            $display("FAIL async_p%0d_final got out=%b left=%0d want out=%b left=0", per, dout, aq.size(), din);
        else passes++;
        m_out  = din;
        m_prev = din;
        q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_toggle();
        test_reset_midflight();
        test_multibit();
        test_back_to_back();
        test_async(10, 4, 7);
        test_async(46, 1, 3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sync_cell.md
Name: sync_cell

Overview:
- Multi-flop level synchronizer that brings a quasi-static or toggle signal from a foreign clock domain into the `clk` domain.
- Used by pulse/toggle CDC blocks, e.g. toggle-based pulse sync with acknowledge, in both the forward and acknowledge directions.
- Optionally provides registered-history edge pulses on the synchronized value, so callers need not build their own delay/XOR.

Parameters:
- WIDTH, 1, number of independent bits synchronized; each bit has its own flop chain. Bits are NOT coherent as a bus; callers may only pass multi-bit values that are Gray-coded or single-bit-change.
- STAGES, 2, number of synchronizer flops in the chain. Legal range 2..4; elaboration error outside this range.
- RST_VAL, {WIDTH{1'b0}}, value loaded into every chain flop and the history register on reset.

Ports:
- clk  in  1  destination-domain clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  WIDTH  asynchronous input from the source domain; may change at any time.
- out  out  WIDTH  synchronized value: the last flop of the chain.
- out_rise  out  WIDTH  one-cycle pulse per bit when out goes 0->1.
- out_fall  out  WIDTH  one-cycle pulse per bit when out goes 1->0.
- out_edge  out  WIDTH  out_rise | out_fall, equal to out XOR out_dly.

Behaviour:
- Chain per bit: stage[0] <= in; stage[i] <= stage[i-1]; out = stage[STAGES-1]. Pure flops, no logic between stages; stage[0] is the only flop sampling in.
- History register: out_dly <= out each clk edge.
- Edge outputs are combinational from out and out_dly only:
  - out_rise = out & ~out_dly
  - out_fall = ~out & out_dly
  - out_edge = out ^ out_dly
- Latency: a level on in that is stable across STAGES rising edges appears on out after exactly STAGES edges. Example: STAGES=2, in changes before edge k -> out changes after edge k+1. The corresponding edge pulse is high for exactly the one cycle between edges k+1 and k+2.
- Metastable sample: if in changes within the setup/hold window, out reflects the change after STAGES or STAGES+1 edges. Never glitches, never shows an intermediate value.
- Reset (rst=1 at a rising edge):
  - All stages and out_dly load RST_VAL at that edge; out = RST_VAL thereafter.
  - All edge outputs = 0 while rst is held, since out == out_dly.
  - Before the first reset edge, outputs are X.
- Reset deassertion: first chain update at the first edge with rst=0. If in differs from RST_VAL, out changes STAGES edges later and emits one edge pulse. Callers wanting no spurious pulse must make in equal RST_VAL at reset.
- Reset mid-operation: pending values in the chain are discarded. No edge pulse is generated by the reset itself.
- Input pulse narrower than one clk period may be lost. Sources must present levels or toggles held for at least 2 clk periods (destination).
- Simultaneous rise and fall on different bits are independent.

Decomposition:
- Shared package cdc_pkg: localparam SYNC_STAGES_DEF = 2, SYNC_STAGES_MIN = 2, SYNC_STAGES_MAX = 4. Reused by pulse-sync and handshake blocks.
- No sub-module: chain, history and edge logic live in sync_cell, generated per bit with a generate loop.
- Chain flops carry the team's synchronizer attribute (ASYNC_REG / dont_touch equivalent) so synthesis keeps them adjacent and unretimed.

Test Plan:
- Reset: rst=1 for 3 edges with in=1, RST_VAL=0 -> out=0, all edge outputs 0. Release rst -> out=1 after 2 edges; out_rise=1 for exactly 1 cycle; out_fall=0.
- Latency: WIDTH=1, STAGES=2; toggle in 0->1 mid-cycle before edge k -> out=1 after edge k+1, out_rise pulse between edges k+1 and k+2. Repeat with STAGES=3: change after edge k+2.
- Toggle stream: in toggles every 4 clk periods for 10 toggles -> exactly 10 out_edge pulses, alternating rise/fall, each 1 cycle wide, each 2 cycles after its toggle.
- Reset mid-flight: in 0->1, assert rst on the very next edge -> out stays 0, no pulse. Release with in=1 -> single out_rise pulse 2 edges later.
- Multi-bit: WIDTH=4, in 4'b0000->4'b0101 -> out=4'b0101 after 2 edges; out_rise=4'b0101 for one cycle. Then in->4'b0100 -> out_fall=4'b0001 for one cycle.
- Async stimulus: in driven from an unrelated clock (ratio 2:1 and 1:2.3), each level held at least 2 destination periods -> out sequence equals in sequence, no missing or extra edge pulses.
